// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
package uart_pkg;

  localparam int DEFAULT_BAUD = 5208;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous level input; reset value is a parameter
// so idle-high lines (rx) and idle-low lines (dtr) both come out of reset quiet.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, one-deep output register.
// Output handshake: a byte transfers on every rising clk edge where valid && ready;
// valid stays high with data stable until that transfer, and data is meaningful only while valid=1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD = DEFAULT_BAUD
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output state_t               state
);

  localparam logic [15:0] HALF = 16'(BAUD / 2);
  localparam logic [15:0] LAST = 16'(BAUD - 1);

  logic                 rx_s;
  state_t               state_nxt;
  logic [15:0]          cnt, cnt_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 deliver;
  logic                 ferr_nxt;
  logic                 load;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_nxt   = '0;
          if (idx == 3'(DATA_BITS - 1)) state_nxt = STOP;
          else                          idx_nxt   = idx + 3'd1;
        end
      end
      STOP: begin
        // Leaving at the mid-stop sample gives half a bit of slack for the next start edge.
        if (cnt == LAST) begin
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load = deliver && (!valid || ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      frame_err <= ferr_nxt;
      overrun   <= deliver && valid && !ready;
    end
  end

endmodule
